ex_mem_pipe: RTL and testbench



---
 rtl/ex_mem_pipe.sv | 133 +++++++++++++
 tb/tb_ex_mem_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// Execute stage plus EX/MEM pipeline register: unpacks the ID/EX bundle, runs the ALU,
// resolves branches/jumps, and squashes the single wrong-path instruction after a taken transfer.
module ex_mem_pipe (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [163:0] ID_CONTENT,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic         STALL,
  input  logic         FLUSH,
  output logic         OUT_VALID,
  output logic [31:0]  ALU_RESULT,
  output logic [31:0]  STORE_DATA,
  output logic [4:0]   WRITE_REG,
  output logic [3:0]   MEM_CTRL,
  output logic         REDIRECT,
  output logic [31:0]  REDIRECT_PC
);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t state_q, state_d;

  logic [31:0] sign_ext, rs, rt, new_pc;
  logic [25:0] instr_lo;
  logic        reg_dst, alu_src, branch, jump;
  logic [1:0]  alu_op;
  logic [3:0]  mem_ctrl_in;

  assign sign_ext    = ID_CONTENT[163:132];
  assign rs          = ID_CONTENT[131:100];
  assign rt          = ID_CONTENT[99:68];
  assign new_pc      = ID_CONTENT[67:36];
  assign instr_lo    = ID_CONTENT[35:10];
  assign reg_dst     = ID_CONTENT[9];
  assign alu_src     = ID_CONTENT[8];
  assign mem_ctrl_in = ID_CONTENT[7:4];
  assign branch      = ID_CONTENT[3];
  assign alu_op      = ID_CONTENT[2:1];
  assign jump        = ID_CONTENT[0];

  logic [31:0] op_a, op_b, diff, alu_y, target;
  logic [4:0]  dest;
  logic        zero, taken, accept, live;

  assign op_a = rs;
  assign op_b = alu_src ? sign_ext : rt;
  assign diff = op_a - op_b;
  assign zero = (diff == 32'd0);

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    alu_y = '0;
    case (alu_op)
      2'b00: alu_y = op_a + op_b;
      2'b01: alu_y = diff;
      2'b11: alu_y = {31'd0, $signed(op_a) < $signed(op_b)};
      default: begin
        case (instr_lo[5:0])
          6'h20:   alu_y = op_a + op_b;
          6'h22:   alu_y = diff;
          6'h24:   alu_y = op_a & op_b;
          6'h25:   alu_y = op_a | op_b;
          6'h2A:   alu_y = {31'd0, $signed(op_a) < $signed(op_b)};
          6'h00:   alu_y = op_b << instr_lo[10:6];
          default: alu_y = '0;
        endcase
      end
    endcase
  end

  // Jump has priority over a branch that happens to be set at the same time.
  assign taken  = jump | (branch & zero);
  assign target = jump ? {new_pc[31:28], instr_lo, 2'b00}
                       : new_pc + {sign_ext[29:0], 2'b00};
  assign dest   = reg_dst ? instr_lo[15:11] : instr_lo[20:16];

  assign IN_READY = !STALL;
  assign accept   = IN_VALID && !STALL;
  assign live     = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    if (FLUSH)
      state_d = RUN;
    else if (accept) begin
      if (state_q == SQUASH)
        state_d = RUN;
      else if (taken)
        state_d = SQUASH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      OUT_VALID   <= 1'b0;
      ALU_RESULT  <= '0;
      STORE_DATA  <= '0;
      WRITE_REG   <= '0;
      MEM_CTRL    <= '0;
      REDIRECT    <= 1'b0;
      REDIRECT_PC <= '0;
    end else begin
      REDIRECT <= 1'b0;
      if (FLUSH) begin
        OUT_VALID <= 1'b0;
        MEM_CTRL  <= '0;
      end else if (accept) begin
        OUT_VALID  <= live;
        ALU_RESULT <= alu_y;
        STORE_DATA <= rt;
        WRITE_REG  <= dest;
        MEM_CTRL   <= live ? mem_ctrl_in : 4'd0;
        if (live && taken) begin
          REDIRECT    <= 1'b1;
          REDIRECT_PC <= target;
        end
      end else if (!STALL) begin
        OUT_VALID <= 1'b0;
        MEM_CTRL  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed-vector bench for ex_mem_pipe with hand-computed expectations.
module tb_ex_mem_pipe;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [163:0] ID_CONTENT;
  logic         IN_VALID, IN_READY, STALL, FLUSH;
  logic         OUT_VALID, REDIRECT;
  logic [31:0]  ALU_RESULT, STORE_DATA, REDIRECT_PC;
  logic [4:0]   WRITE_REG;
  logic [3:0]   MEM_CTRL;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [9:0] C_RTYPE = 10'h244;  // REG_DST, REG_WRITE, ALU_OP=10
  localparam logic [9:0] C_LOAD  = 10'h1E0;  // ALU_SRC, MEM_TO_REG, REG_WRITE, MEM_READ
  localparam logic [9:0] C_BEQ   = 10'h00A;  // BRANCH, ALU_OP=01
  localparam logic [9:0] C_JMPBR = 10'h009;  // JUMP and BRANCH both set

  ex_mem_pipe dut (
    .CLK(CLK), .RESET(RESET), .ID_CONTENT(ID_CONTENT), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .STALL(STALL), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
    .ALU_RESULT(ALU_RESULT), .STORE_DATA(STORE_DATA), .WRITE_REG(WRITE_REG),
    .MEM_CTRL(MEM_CTRL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [163:0] bundle(input logic [31:0] se, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] npc,
                                          input logic [25:0] lo, input logic [9:0] ctrl);
    return {se, a, b, npc, lo, ctrl};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic add_vec(input logic [4:0] rd);
    ID_CONTENT = bundle(32'd0, 32'd5, 32'd7, 32'd0, {10'd0, rd, 5'd0, 6'h20}, C_RTYPE);
    IN_VALID   = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd0);
    check({tag, "_alu"}, ALU_RESULT, 32'd0);
    check({tag, "_store"}, STORE_DATA, 32'd0);
    check({tag, "_wreg"}, {27'd0, WRITE_REG}, 32'd0);
    check({tag, "_mctl"}, {28'd0, MEM_CTRL}, 32'd0);
    check({tag, "_redir"}, {31'd0, REDIRECT}, 32'd0);
    check({tag, "_rpc"}, REDIRECT_PC, 32'd0);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } rvec_t;

  rvec_t rtab [6] = '{
    '{32'h0000_00F0, 32'h0000_0F3C, 6'h24, 5'd0, 32'h0000_0030},  // and
    '{32'h0000_00F0, 32'h0000_0F0C, 6'h25, 5'd0, 32'h0000_0FFC},  // or
    '{32'h0000_0003, 32'h0000_0005, 6'h22, 5'd0, 32'hFFFF_FFFE},  // sub wraps
    '{32'hFFFF_FFFF, 32'h0000_0001, 6'h2A, 5'd0, 32'h0000_0001},  // slt signed
    '{32'h0000_0000, 32'h0000_0003, 6'h00, 5'd4, 32'h0000_0030},  // sll
    '{32'h0000_0009, 32'h0000_0003, 6'h27, 5'd0, 32'h0000_0000}   // unknown funct
  };

  initial begin
    RESET = 1'b0; STALL = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; ID_CONTENT = '0;
    #3;
    check("rst_ready_stall", {31'd0, IN_READY}, 32'd0);
    STALL = 1'b0;
    #1;
    check("rst_ready", {31'd0, IN_READY}, 32'd1);
    check_all_zero("rst");
    @(negedge CLK);
    RESET = 1'b1;

    // R-type add
    add_vec(5'd3);
    step();
    check("add_valid", {31'd0, OUT_VALID}, 32'd1);
    check("add_alu", ALU_RESULT, 32'd12);
    check("add_wreg", {27'd0, WRITE_REG}, 32'd3);
    check("add_mctl", {28'd0, MEM_CTRL}, 32'h4);
    check("add_store", STORE_DATA, 32'd7);

    // Remaining R-type functs
    foreach (rtab[i]) begin
      ID_CONTENT = bundle(32'd0, rtab[i].a, rtab[i].b, 32'd0,
                          {10'd0, 5'd1, rtab[i].shamt, rtab[i].funct}, C_RTYPE);
      step();
      check($sformatf("rtype%0d_alu", i), ALU_RESULT, rtab[i].exp);
    end

    // Load, then three stall cycles with a different bundle offered
    ID_CONTENT = bundle(32'hFFFF_FFFC, 32'h0000_1000, 32'h0000_00AA, 32'd0,
                        {5'd0, 5'd4, 16'd0}, C_LOAD);
    step();
    check("ld_alu", ALU_RESULT, 32'h0000_0FFC);
    check("ld_mctl", {28'd0, MEM_CTRL}, 32'hE);
    check("ld_wreg", {27'd0, WRITE_REG}, 32'd4);
    add_vec(5'd9);
    STALL = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_ready", {31'd0, IN_READY}, 32'd0);
      check("stall_alu", ALU_RESULT, 32'h0000_0FFC);
      check("stall_mctl", {28'd0, MEM_CTRL}, 32'hE);
      check("stall_wreg", {27'd0, WRITE_REG}, 32'd4);
      check("stall_valid", {31'd0, OUT_VALID}, 32'd1);
    end

    // Released with nothing offered -> bubble
    STALL = 1'b0; IN_VALID = 1'b0;
    step();
    check("bubble_valid", {31'd0, OUT_VALID}, 32'd0);
    check("bubble_mctl", {28'd0, MEM_CTRL}, 32'd0);

    // Not-taken BEQ
    ID_CONTENT = bundle(32'd4, 32'd9, 32'd8, 32'h40, 26'd0, C_BEQ);
    IN_VALID = 1'b1;
    step();
    check("bne_redir", {31'd0, REDIRECT}, 32'd0);
    check("bne_valid", {31'd0, OUT_VALID}, 32'd1);

    // Taken BEQ, squashed add, then a live add
    ID_CONTENT = bundle(32'd4, 32'd9, 32'd9, 32'h40, 26'd0, C_BEQ);
    step();
    check("beq_redir", {31'd0, REDIRECT}, 32'd1);
    check("beq_rpc", REDIRECT_PC, 32'h50);
    check("beq_valid", {31'd0, OUT_VALID}, 32'd1);
    check("beq_alu", ALU_RESULT, 32'd0);
    add_vec(5'd3);
    step();
    check("sq_redir", {31'd0, REDIRECT}, 32'd0);
    check("sq_valid", {31'd0, OUT_VALID}, 32'd0);
    check("sq_mctl", {28'd0, MEM_CTRL}, 32'd0);
    step();
    check("post_sq_valid", {31'd0, OUT_VALID}, 32'd1);
    check("post_sq_mctl", {28'd0, MEM_CTRL}, 32'h4);

    // Jump (BRANCH also set with zero true: jump target must win), stall right after
    ID_CONTENT = bundle(32'd1, 32'd0, 32'd0, 32'h8000_0004, 26'h000_0010, C_JMPBR);
    step();
    check("jmp_redir", {31'd0, REDIRECT}, 32'd1);
    check("jmp_rpc", REDIRECT_PC, 32'h8000_0040);
    STALL = 1'b1;
    step();
    check("jmp_stall_redir", {31'd0, REDIRECT}, 32'd0);
    check("jmp_stall_rpc", REDIRECT_PC, 32'h8000_0040);
    check("jmp_stall_valid", {31'd0, OUT_VALID}, 32'd1);

    // FLUSH in SQUASH with a taken jump offered under stall
    FLUSH = 1'b1;
    step();
    check("flush_valid", {31'd0, OUT_VALID}, 32'd0);
    check("flush_mctl", {28'd0, MEM_CTRL}, 32'd0);
    check("flush_redir", {31'd0, REDIRECT}, 32'd0);
    FLUSH = 1'b0; STALL = 1'b0;
    add_vec(5'd3);
    step();
    check("after_flush_valid", {31'd0, OUT_VALID}, 32'd1);
    check("after_flush_mctl", {28'd0, MEM_CTRL}, 32'h4);

    // Asynchronous reset between edges
    #2;
    STALL = 1'b1;
    RESET = 1'b0;
    #1;
    check_all_zero("async");
    check("async_ready", {31'd0, IN_READY}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1; STALL = 1'b0;
    add_vec(5'd7);
    step();
    check("rel_valid", {31'd0, OUT_VALID}, 32'd1);
    check("rel_wreg", {27'd0, WRITE_REG}, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
